// File: rtl/uart_break_rst.sv
// UART break detector: a low line held longer than any legal character
// yields one stretched reset request, then waits for an idle line to re-arm.
module uart_break_rst #(
    parameter int unsigned P_CLK_FREQ   = 50_000_000,
    parameter int unsigned P_UART_BAUD  = 115200,
    parameter int unsigned P_BREAK_BITS = 12,
    parameter int unsigned P_RST_CYCLE  = 16,
    parameter int unsigned P_IDLE_BITS  = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_uart_rx,
    input  logic i_enable,
    output logic o_rst,
    output logic o_break_det,
    output logic o_busy
);

    localparam int unsigned B_CYC = P_CLK_FREQ / P_UART_BAUD;
    // Compare against the pre-increment value so the count "reaches" L / H
    // on the same edge that acts on it.
    localparam logic [31:0] L_LAST  = 32'(B_CYC * P_BREAK_BITS - 1);
    localparam logic [31:0] H_LAST  = 32'(B_CYC * P_IDLE_BITS - 1);
    localparam logic [31:0] RST_LEN = 32'(P_RST_CYCLE);

    typedef enum logic [1:0] {
        IDLE,
        LOW_CNT,
        RST_OUT,
        WAIT_IDLE
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] cnt_inc;
    logic [1:0]  sync_q;
    logic        rst_q;
    logic        det_q;
    logic        rx_s;

    assign rx_s    = sync_q[1];
    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 32'd1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (i_enable && !rx_s) begin
                    state_d = LOW_CNT;
                    cnt_d   = 32'd1;
                end else begin
                    cnt_d = '0;
                end
            end
            LOW_CNT: begin
                if (rx_s || !i_enable) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == L_LAST) begin
                    state_d = RST_OUT;
                    cnt_d   = 32'd1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            RST_OUT: begin
                if (cnt_q == RST_LEN) begin
                    state_d = WAIT_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            WAIT_IDLE: begin
                if (!rx_s) begin
                    cnt_d = '0;
                end else if (cnt_q == H_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sync_q  <= 2'b11;
            rst_q   <= 1'b0;
            det_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sync_q  <= {sync_q[0], i_uart_rx};
            rst_q   <= (state_d == RST_OUT);
            det_q   <= (state_q == LOW_CNT) && (state_d == RST_OUT);
        end
    end

    assign o_rst       = rst_q;
    assign o_break_det = det_q;
    assign o_busy      = (state_q != IDLE);

endmodule

// File: doc/uart_break_rst.md
# uart_break_rst

UART break detector and reset requester. It watches the UART receive line, declares a break when the line is held low longer than any legal character, and issues a stretched active-high reset pulse. This lets a host reset the UART datapath remotely. It sits beside the power-on reset generator, and its `o_rst` is ORed with the power-on reset at the top level.

## Interface
- `P_CLK_FREQ`, 50_000_000: system clock frequency in Hz.
- `P_UART_BAUD`, 115200: line baud rate.
- `P_BREAK_BITS`, 12: bit periods of continuous low that qualify as a break. Must be ≥ 10.
- `P_RST_CYCLE`, 16: length of the `o_rst` pulse in clocks. Legal range 1..255.
- `P_IDLE_BITS`, 2: bit periods of continuous high required before the block re-arms.
- `i_clk` input 1: system clock. All logic is on the rising edge.
- `i_rst_n` input 1: synchronous, active-low reset.
- `i_uart_rx` input 1: asynchronous UART RX line, idle high.
- `i_enable` input 1: arms break detection.
- `o_rst` output 1: active-high reset request, registered.
- `o_break_det` output 1: one-cycle pulse when a break is declared.
- `o_busy` output 1: high in any state other than IDLE.

## Operation
- Derived constants:
  - B = P_CLK_FREQ / P_UART_BAUD, integer division.
  - L = B × P_BREAK_BITS.
  - H = B × P_IDLE_BITS.
- Counters are 32 bits wide and saturate; they never wrap.
- `i_uart_rx` passes through a 2-flop synchronizer, giving `rx_s`. Both synchronizer flops reset to 1.
- FSM states: IDLE, LOW_CNT, RST_OUT, WAIT_IDLE.
  - **IDLE:** if `i_enable`=1 and `rx_s`=0, go to LOW_CNT with cnt=1. Otherwise stay, with cnt=0.
  - **LOW_CNT:**
    - `rx_s`=1 (glitch or ordinary character) → IDLE, cnt cleared.
    - `i_enable`=0 → IDLE.
    - `rx_s`=0 and cnt=L → RST_OUT: `o_rst`←1, `o_break_det`←1 for one cycle, cnt←1.
    - Otherwise cnt+1.
  - **RST_OUT:** `o_rst` stays 1. When cnt=P_RST_CYCLE, `o_rst`←0 → WAIT_IDLE, cnt←0. Otherwise cnt+1. `i_enable` and `rx_s` are ignored, so the pulse always completes.
  - **WAIT_IDLE:**
    - `rx_s`=0 → cnt←0.
    - `rx_s`=1 → cnt+1.
    - On cnt reaching H with `rx_s`=1 → IDLE.
    - A line held low indefinitely therefore produces exactly one pulse.
- Priority: `i_rst_n` over everything, then the FSM rules above. When `i_enable` drops and `rx_s` rises in the same cycle in LOW_CNT, the result is IDLE either way.
- Reset values: state IDLE, counters 0, `o_rst`=0, `o_break_det`=0, `o_busy`=0, sync flops 1.
- Reset asserted in the middle of RST_OUT truncates the pulse. `o_rst` is 0 after the first edge with `i_rst_n`=0.

## Timing
- Let edge 0 be the first edge that samples `i_uart_rx`=0 with the block in IDLE and enabled.
- `rx_s` is low after edge 1.
- LOW_CNT is entered at edge 2.
- `o_rst` and `o_break_det` are first high after edge L+1, provided `i_uart_rx` stays low through edge L−1.
- `o_rst` stays high exactly P_RST_CYCLE cycles.
- `o_break_det` is high exactly 1 cycle, aligned with the first `o_rst` cycle.
- `o_busy` is high from edge 2 through the edge that returns the FSM to IDLE.
- Re-arm: IDLE is re-entered H cycles after `rx_s` is continuously high in WAIT_IDLE.

## Test plan
Bench parameters: P_CLK_FREQ=1000, P_UART_BAUD=100, P_BREAK_BITS=12, P_RST_CYCLE=5, P_IDLE_BITS=2. This gives B=10, L=120, H=20.

1. **Reset values.** Hold `i_rst_n`=0 for 3 cycles with `i_uart_rx`=0, then release with rx=1 → all outputs 0 throughout; no break is declared.
2. **Basic break.** Enable, then drive rx low for 200 cycles → `o_rst`=1 after edge 121 for exactly 5 cycles; one `o_break_det` pulse; no second pulse while rx stays low.
3. **Legal character is not a break.** Send byte 0x00 at 100 baud (90 cycles low), then rx high; also drive a 119-cycle low pulse → `o_rst` never asserts; FSM returns to IDLE and `o_busy`=0.
4. **Re-arm.** After test 2, drive rx high 15 cycles, low 3, then high 20 → IDLE is re-entered only after the final 20 high cycles. A new 130-cycle low then produces a second 5-cycle pulse.
5. **Enable handling.** Drop `i_enable` at cycle 60 of a low period → no pulse. Drop `i_enable` during RST_OUT → the pulse still completes its 5 cycles.
6. **Reset mid-pulse.** Assert `i_rst_n`=0 on the 3rd cycle of `o_rst` → `o_rst`=0 after that edge; after release with rx low, a full 120-cycle count is required again before any pulse.
